// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the layer sequencer and the network controller:
// default counter/address widths and the sequencer state encoding.
package layer_sequencer_pkg;

    localparam int unsigned IDX_W   = 6;
    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE = STATE_W'(0);
    localparam logic [STATE_W-1:0] ST_CLR  = STATE_W'(1);
    localparam logic [STATE_W-1:0] ST_MAC  = STATE_W'(2);
    localparam logic [STATE_W-1:0] ST_ACT  = STATE_W'(3);
    localparam logic [STATE_W-1:0] ST_WB   = STATE_W'(4);
    localparam logic [STATE_W-1:0] ST_DONE = STATE_W'(5);

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = ST_IDLE,
        S_CLR  = ST_CLR,
        S_MAC  = ST_MAC,
        S_ACT  = ST_ACT,
        S_WB   = ST_WB,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/layer_sequencer_if.sv
// Handshake/bus bundle between the network controller / result buffer
// (master side) and the layer sequencer (slave side).
//   start, cfg_*      : layer request and its configuration
//   wr_ready          : result buffer accept
//   in_idx .. w_addr  : datapath indices and weight address
//   mac_clr .. wr_en  : datapath strobes
//   busy, calculation_done : status back to the controller
interface layer_sequencer_if;
    import layer_sequencer_pkg::*;

    logic              start;
    logic [IDX_W-1:0]  cfg_in_cnt;
    logic [IDX_W-1:0]  cfg_neu_cnt;
    logic [ADDR_W-1:0] cfg_w_base;
    logic              wr_ready;
    logic [IDX_W-1:0]  in_idx;
    logic [IDX_W-1:0]  neu_idx;
    logic [ADDR_W-1:0] w_addr;
    logic              mac_clr;
    logic              mac_en;
    logic              act_en;
    logic              wr_en;
    logic              busy;
    logic              calculation_done;

    modport master (
        output start, cfg_in_cnt, cfg_neu_cnt, cfg_w_base, wr_ready,
        input  in_idx, neu_idx, w_addr, mac_clr, mac_en, act_en, wr_en,
               busy, calculation_done
    );

    modport slave (
        input  start, cfg_in_cnt, cfg_neu_cnt, cfg_w_base, wr_ready,
        output in_idx, neu_idx, w_addr, mac_clr, mac_en, act_en, wr_en,
               busy, calculation_done
    );

endinterface

// File: rtl/layer_sequencer_idx_counter.sv
// Loadable up-counter with enable and terminal-count compare.
//   clk, rst  : clock, async active-high reset
//   load      : load load_val (priority over en)
//   en        : increment by one
//   term      : count length; last_c flags cnt == term-1
//   cnt       : registered count
module idx_counter #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         last_c
);

    assign last_c = (cnt == term - W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Steps one shared MAC neuron datapath across all neurons of a layer:
// clear, accumulate over inputs, activate, write back, then pulse done.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of layer_sequencer_if (request, cfg, datapath
//              indices/strobes, busy and calculation_done)
module layer_sequencer
    import layer_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    layer_sequencer_if.slave   bus
);

    state_t            state;
    logic [IDX_W-1:0]  in_cnt_r;
    logic [IDX_W-1:0]  neu_cnt_r;
    logic [ADDR_W-1:0] w_addr_r;
    logic [IDX_W-1:0]  in_idx_r;
    logic [IDX_W-1:0]  neu_idx_r;
    logic              mac_clr_r;
    logic              mac_en_r;
    logic              act_en_r;
    logic              wr_en_r;
    logic              busy_r;
    logic              done_r;

    logic in_last_c;
    logic neu_last_c;
    logic launch_c;
    logic wb_next_c;
    logic abort_c;

    // Counter control is decoded from the current state so the counters
    // move on the same edge as the state register.
    assign launch_c  = (state == S_IDLE) && bus.start;
    assign wb_next_c = (state == S_WB) && bus.start && bus.wr_ready && !neu_last_c;
    assign abort_c   = !bus.start && (state inside {S_CLR, S_MAC, S_ACT, S_WB});

    idx_counter #(.W(IDX_W)) u_in_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (launch_c || wb_next_c),
        .load_val ('0),
        .en       ((state == S_MAC) && bus.start),
        .term     (in_cnt_r),
        .cnt      (in_idx_r),
        .last_c   (in_last_c)
    );

    idx_counter #(.W(IDX_W)) u_neu_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (launch_c),
        .load_val ('0),
        .en       (wb_next_c),
        .term     (neu_cnt_r),
        .cnt      (neu_idx_r),
        .last_c   (neu_last_c)
    );

    // State register; each output is registered with the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            in_cnt_r  <= '0;
            neu_cnt_r <= '0;
            w_addr_r  <= '0;
            mac_clr_r <= 1'b0;
            mac_en_r  <= 1'b0;
            act_en_r  <= 1'b0;
            wr_en_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            mac_clr_r <= 1'b0;
            mac_en_r  <= 1'b0;
            act_en_r  <= 1'b0;
            wr_en_r   <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b1;

            if (abort_c) begin
                state  <= S_IDLE;
                busy_r <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        busy_r <= 1'b0;
                        if (bus.start) begin
                            in_cnt_r  <= bus.cfg_in_cnt;
                            neu_cnt_r <= bus.cfg_neu_cnt;
                            w_addr_r  <= bus.cfg_w_base;
                            busy_r    <= 1'b1;
                            if (bus.cfg_neu_cnt == '0) begin
                                state  <= S_DONE;
                                done_r <= 1'b1;
                            end else begin
                                state     <= S_CLR;
                                mac_clr_r <= 1'b1;
                            end
                        end
                    end
                    S_CLR: begin
                        if (in_cnt_r == '0) begin
                            state    <= S_ACT;
                            act_en_r <= 1'b1;
                        end else begin
                            state    <= S_MAC;
                            mac_en_r <= 1'b1;
                        end
                    end
                    S_MAC: begin
                        // Address keeps running across neurons: rows are contiguous.
                        w_addr_r <= w_addr_r + ADDR_W'(1);
                        if (in_last_c) begin
                            state    <= S_ACT;
                            act_en_r <= 1'b1;
                        end else begin
                            mac_en_r <= 1'b1;
                        end
                    end
                    S_ACT: begin
                        state   <= S_WB;
                        wr_en_r <= 1'b1;
                    end
                    S_WB: begin
                        if (!bus.wr_ready) begin
                            wr_en_r <= 1'b1;
                        end else if (neu_last_c) begin
                            state  <= S_DONE;
                            done_r <= 1'b1;
                        end else begin
                            state     <= S_CLR;
                            mac_clr_r <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        // start is ignored here so a held request cannot retrigger.
                        state  <= S_IDLE;
                        busy_r <= 1'b0;
                    end
                    default: begin
                        state  <= S_IDLE;
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.in_idx           = in_idx_r;
    assign bus.neu_idx          = neu_idx_r;
    assign bus.w_addr           = w_addr_r;
    assign bus.mac_clr          = mac_clr_r;
    assign bus.mac_en           = mac_en_r;
    assign bus.act_en           = act_en_r;
    assign bus.wr_en            = wr_en_r;
    assign bus.busy             = busy_r;
    assign bus.calculation_done = done_r;

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Sequences one shared multiply-accumulate neuron datapath across every neuron of one network layer: clears the accumulator, steps through inputs and weights, applies activation, writes each result back.
- Sits between the top-level network controller and the neuron/MAC datapath.
- Consumes the controller's level-held start request and returns a one-cycle calculation_done pulse when the whole layer is finished.

Parameters:
- IDX_W, 6, width of input and neuron index counters (max 63 inputs / 63 neurons per layer).
- ADDR_W, 12, width of the weight-memory address.

Ports:
- clk  in  1  clock.
- rst  in  1  reset (see Behaviour).
- start  in  1  level request from the network controller; held high for the whole layer.
- cfg_in_cnt  in  IDX_W  number of inputs per neuron; sampled at start.
- cfg_neu_cnt  in  IDX_W  number of neurons in the layer; sampled at start.
- cfg_w_base  in  ADDR_W  first weight address of the layer; sampled at start.
- wr_ready  in  1  result buffer can accept a write this cycle.
- in_idx  out  IDX_W  input-vector index for the current MAC cycle.
- neu_idx  out  IDX_W  neuron currently being computed.
- w_addr  out  ADDR_W  weight address for the current MAC cycle.
- mac_clr  out  1  clear accumulator (loads bias).
- mac_en  out  1  accumulate in_idx/w_addr product.
- act_en  out  1  register activation of accumulator.
- wr_en  out  1  write activated result to slot neu_idx.
- busy  out  1  high in any state other than IDLE.
- calculation_done  out  1  one-cycle pulse: layer complete.

Behaviour:
- Reset is asynchronous and active-high on rst; the block is clocked on the rising edge of clk.
- Reset values: state IDLE, all counters 0, all outputs 0.
- FSM states: IDLE, CLR, MAC, ACT, WB, DONE. All outputs are registered or decoded from state only; no combinational path from start to outputs.
- IDLE:
  - On start=1, latch cfg_* into internal registers; neu_idx=0; in_idx=0; w_addr=cfg_w_base.
  - If cfg_neu_cnt=0, go to DONE; else go to CLR.
- CLR: mac_clr=1 for 1 cycle. If in_cnt_r=0, go to ACT; else go to MAC.
- MAC:
  - mac_en=1 every cycle.
  - in_idx and w_addr each increment by 1 after each cycle.
  - Leave MAC after the cycle with in_idx=in_cnt_r-1; next state ACT.
- ACT: act_en=1 for 1 cycle; next state WB.
- WB:
  - wr_en=1 while waiting; hold in WB while wr_ready=0 (stall), with all indices frozen.
  - On wr_ready=1: if neu_idx=neu_cnt_r-1, go to DONE; else neu_idx+1, in_idx=0, go to CLR.
  - w_addr continues from its current value, so weights are row-contiguous.
- DONE: calculation_done=1 for exactly 1 cycle; next state IDLE.
  - start is re-sampled only in IDLE, so a start still high from the same request cannot retrigger within the DONE cycle.
  - A new start seen in IDLE on the following cycle launches the next layer. This matches the controller, which leaves its state on calculation_done and raises start again for the next layer.
- Latency, no stall: DONE occurs N*(M+3) cycles after the IDLE cycle that sampled start, with M = in count and N = neuron count. The case M=0 is covered by the same formula.
- Abort: start=0 in any state other than IDLE or DONE returns the FSM to IDLE next cycle. No calculation_done and no further wr_en are issued.
- cfg_* changes after sampling have no effect until the next start.
- Width rules:
  - w_addr wraps modulo 2^ADDR_W with no error flag.
  - Counters compare against the latched counts; cfg value 0 is legal as defined above.
- Reset mid-operation: immediate return to IDLE with all outputs 0, including a pulse in flight.

Decomposition:
- Shared package: state encoding (localparams for the 6 states) and default IDX_W/ADDR_W values, reused by the network controller.
- Sub-module idx_counter: loadable up-counter with enable and a terminal-count compare, instantiated for in_idx and neu_idx.
- The FSM stays in layer_sequencer.

Test Plan:
- M=2, N=2, base=0x010, wr_ready=1 -> w_addr sequence 0x010,0x011,0x012,0x013 under mac_en; wr_en at neu_idx 0 then 1; calculation_done pulse 10 cycles after the start-sample cycle; busy low afterwards.
- N=0, start=1 -> DONE on the cycle after the start-sample cycle; calculation_done 1 cycle; no mac_clr or wr_en.
- M=0, N=3 -> per neuron only CLR,ACT,WB with no mac_en; 3 wr_en pulses; done at cycle 9.
- M=3, N=1, wr_ready=0 for 4 cycles in WB -> wr_en held 5 cycles with neu_idx stable; done delayed by exactly 4 cycles.
- Abort: start dropped during the 2nd MAC cycle -> IDLE next cycle; no wr_en and no calculation_done; a restart with new cfg uses the new base.
- rst asserted mid-MAC, then released with start high -> all outputs 0 during reset; a fresh full layer sequence then runs from neu_idx=0.
